uart_tx_cfg: RTL and testbench
==============================

# uart_tx_cfg

Parametrised UART transmitter for the serial I/O path. It serialises one parallel word per request onto a single `tx` line, LSB first, framed by a start bit and one or two stop bits. Data width, baud divisor and stop-bit count are set by parameters, and an optional parity bit is selected at compile time. It is the configurable successor to the fixed 8N1 transmitter, and it adds a `busy` level, a one-cycle `tx_done` pulse and gap-free back-to-back frames.

## Interface
- `DATA_BITS`, default 8: payload bits per frame; legal range 5–9.
- `BAUD_DIV`, default 2604: clocks per bit period; must be ≥ 2.
- `STOP_BITS`, default 1: stop bits per frame; legal values 1 or 2.
- `PARITY_ODD`, default 0: 0 selects even parity, 1 selects odd. Only used when parity is compiled in.

- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous reset, active-high.
- `strt_tx`  in  1  request to send; acts only when not `busy`.
- `tx_data`  in  `DATA_BITS`  payload; sampled in the cycle `strt_tx` is accepted.
- `tx`  out  1  serial line, registered; idles high.
- `busy`  out  1  high from the cycle after acceptance until the frame ends.
- `tx_done`  out  1  one-cycle pulse in the last clock of the final stop bit.

## Operation
- Reset values:
  - `tx` = 1, `busy` = 0, `tx_done` = 0.
  - State = IDLE.
  - Baud counter, bit index and shift register cleared; the shift register fills with ones.
- States and transitions:
  - IDLE: `tx` = 1. On `strt_tx`, latch `tx_data` and go to START.
  - START: `tx` = 0 for `BAUD_DIV` clocks, then go to DATA.
  - DATA: drive `DATA_BITS` bits LSB first, `BAUD_DIV` clocks each. Then go to PAR if parity is compiled in, otherwise to STOP.
  - PAR: drive the parity bit for one bit period, then go to STOP.
  - STOP: `tx` = 1 for `STOP_BITS` × `BAUD_DIV` clocks. `tx_done` pulses in the final clock. Then:
    - if `strt_tx` is high in that same clock, latch new data and go to START;
    - otherwise go to IDLE.
- Baud counter:
  - `$clog2(BAUD_DIV)` bits wide.
  - Counts 0 to `BAUD_DIV`−1, then wraps to 0 and advances the bit.
  - Cleared on every frame acceptance.
- Bit index: `$clog2(DATA_BITS+1)` bits wide; counts data bits and stop bits. It never wraps within a frame.
- Handshake:
  - `strt_tx` while busy is ignored, except in the final STOP clock.
  - `tx_data` changes after acceptance do not affect the frame in flight.
- Frame length in clocks: (1 + `DATA_BITS` + P + `STOP_BITS`) × `BAUD_DIV`, where P = 1 with parity and 0 without.

## Timing
- Latency: `strt_tx` accepted at clock edge N gives `tx` = 0 and `busy` = 1 from edge N+1.
- Each bit is held for exactly `BAUD_DIV` clocks, with no jitter or cumulative drift.
- `tx_done` is high for exactly one clock per frame, including back-to-back frames.
- Back-to-back frames:
  - `busy` stays high across the boundary.
  - The start bit of frame 2 begins on the clock after `tx_done`, with zero idle gap.
- Without back-to-back: `busy` falls on the clock after `tx_done`.
- `rst` asserted mid-frame: `tx` goes to 1 and `busy` to 0 immediately (asynchronous). The frame is dropped and no `tx_done` is issued.
- `rst` deasserted with `strt_tx` already high: the request is accepted on the first clock edge after release.

## Configuration
- Macro `UART_TX_PARITY_EN`.
- Defined:
  - The PAR state exists.
  - The parity bit is XOR of the payload for even parity, or its inverse when `PARITY_ODD` = 1.
  - The parity bit is sent between the last data bit and the stop bit(s).
- Undefined:
  - PAR state and parity logic are absent.
  - `PARITY_ODD` is ignored.
  - Frame is 1 + `DATA_BITS` + `STOP_BITS` bits.

## Test plan
- Config: `DATA_BITS`=8, `BAUD_DIV`=16, `STOP_BITS`=1, parity off. Send `tx_data`=0xA5.
  - `tx` sequence: 0, 1,0,1,0,0,1,0,1, 1, each bit held 16 clocks.
  - `tx_done` pulses at clock 160 after acceptance; `busy` falls at clock 161.
- Parity on, even, send 0xA5 → parity bit 0. Parity on, odd, send 0x07 → parity bit 0. Frame is 176 clocks.
- `DATA_BITS`=5, `STOP_BITS`=2, send 0x1F → 0, 1,1,1,1,1, 1,1. Frame is 128 clocks.
- Hold `strt_tx`=1 continuously, data 0x3C then 0xC3:
  - no idle gap between frames;
  - two `tx_done` pulses exactly 160 clocks apart;
  - `busy` never drops between the frames.
- Pulse `strt_tx` at clock 40 of a frame → ignored; the frame and `tx_done` timing are unchanged.
- Assert `rst` at clock 70 of a frame → `tx`=1, `busy`=0 in the same cycle. No `tx_done`. After release, a fresh frame of 0x55 is sent correctly.

Source files
------------

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: parametrised LSB-first UART transmitter with gap-free back-to-back frames.
// Optional parity bit when the UART_TX_PARITY_EN macro is defined.
module uart_tx_cfg #(
  parameter int unsigned DATA_BITS  = 8,
  parameter int unsigned BAUD_DIV   = 2604,
  parameter int unsigned STOP_BITS  = 1,
  parameter bit          PARITY_ODD = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 strt_tx,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx,
  output logic                 busy,
  output logic                 tx_done
);

  localparam int unsigned CW = $clog2(BAUD_DIV);
  localparam int unsigned IW = $clog2(DATA_BITS + 1);
  localparam logic [CW-1:0] CNT_LAST  = CW'(BAUD_DIV - 1);
  localparam logic [IW-1:0] DATA_LAST = IW'(DATA_BITS - 1);
  localparam logic [IW-1:0] STOP_LAST = IW'(STOP_BITS - 1);

  // Out-of-range configurations are flagged by this marker scope.
  if (DATA_BITS < 5 || DATA_BITS > 9 || BAUD_DIV < 2 ||
      (STOP_BITS != 1 && STOP_BITS != 2) ||
      PARITY_ODD > 1'b1) begin : g_illegal_cfg
  end

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE, START, DATA, PAR, STOP
  } state_e;
`else
  typedef enum logic [2:0] {
    IDLE, START, DATA, STOP
  } state_e;
`endif

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [IW-1:0]        idx_q, idx_d;
  logic [DATA_BITS-1:0] sh_q, sh_d;
  logic                 tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
  logic                 par_q, par_d;
`endif

  logic bit_end;
  logic frame_end;
  logic accept;

  assign bit_end   = (cnt_q == CNT_LAST);
  assign frame_end = (state_q == STOP) && bit_end &&
                     (idx_q == STOP_LAST);
  // A request in the final stop clock chains the next frame.
  assign accept    = strt_tx &&
                     ((state_q == IDLE) || frame_end);

  assign tx      = tx_q;
  assign busy    = (state_q != IDLE);
  assign tx_done = frame_end;

  always_comb begin
    state_d = state_q;
    cnt_d   = bit_end ? '0 : cnt_q + 1'b1;
    idx_d   = idx_q;
    sh_d    = sh_q;
    tx_d    = tx_q;
`ifdef UART_TX_PARITY_EN
    par_d   = par_q;
`endif
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        tx_d  = 1'b1;
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          idx_d   = '0;
          tx_d    = sh_q[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (idx_q == DATA_LAST) begin
            idx_d   = '0;
`ifdef UART_TX_PARITY_EN
            state_d = PAR;
            tx_d    = par_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            idx_d = idx_q + 1'b1;
            sh_d  = {1'b1, sh_q[DATA_BITS-1:1]};
            tx_d  = sh_q[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PAR: begin
        if (bit_end) begin
          state_d = STOP;
          idx_d   = '0;
          tx_d    = 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          if (idx_q == STOP_LAST) begin
            state_d = IDLE;
            tx_d    = 1'b1;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
    if (accept) begin
      state_d = START;
      cnt_d   = '0;
      idx_d   = '0;
      sh_d    = tx_data;
      tx_d    = 1'b0;
`ifdef UART_TX_PARITY_EN
      par_d   = (^tx_data) ^ PARITY_ODD;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      sh_q    <= '1;
      tx_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
`ifdef UART_TX_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: table vectors, corner sequences and random frames
// checked cycle by cycle against a frame-level model.
module tb_uart_tx_cfg;

  localparam int B = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       strt_a = 1'b0;
  logic       strt_b = 1'b0;
  logic [7:0] data_a = '0;
  logic [4:0] data_b = '0;
  logic       tx_a, busy_a, done_a;
  logic       tx_b, busy_b, done_b;

  always #5 clk = ~clk;

  uart_tx_cfg #(
    .DATA_BITS(8), .BAUD_DIV(B),
    .STOP_BITS(1), .PARITY_ODD(1'b0)
  ) dut_a (
    .clk(clk), .rst(rst),
    .strt_tx(strt_a), .tx_data(data_a),
    .tx(tx_a), .busy(busy_a), .tx_done(done_a)
  );

  uart_tx_cfg #(
    .DATA_BITS(5), .BAUD_DIV(B),
    .STOP_BITS(2), .PARITY_ODD(1'b1)
  ) dut_b (
    .clk(clk), .rst(rst),
    .strt_tx(strt_b), .tx_data(data_b),
    .tx(tx_b), .busy(busy_b), .tx_done(done_b)
  );

  int vecs = 0;
  int miss = 0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      miss++;
      $display("FAIL %s: got %0h expected %0h at %0t",
               nm, act, exp, $time);
    end
  endtask

  function automatic logic otx(input int sel);
    return sel != 0 ? tx_b : tx_a;
  endfunction
  function automatic logic obusy(input int sel);
    return sel != 0 ? busy_b : busy_a;
  endfunction
  function automatic logic odone(input int sel);
    return sel != 0 ? done_b : done_a;
  endfunction

  task automatic drv(input int sel, input logic s,
                     input logic [8:0] d);
    if (sel != 0) begin
      strt_b = s;
      data_b = d[4:0];
    end else begin
      strt_a = s;
      data_a = d[7:0];
    end
  endtask

  // Frame as a bit list: start, data LSB first, parity, stops.
  function automatic void model(input int sel,
                                input logic [8:0] d,
                                output logic [15:0] f,
                                output int n);
    int db = (sel != 0) ? 5 : 8;
    int sb = (sel != 0) ? 2 : 1;
    logic p = (sel != 0) ? 1'b1 : 1'b0;
    f = '0;
    n = 1;
    for (int i = 0; i < db; i++) begin
      f[n] = d[i];
      p = p ^ d[i];
      n++;
    end
`ifdef UART_TX_PARITY_EN
    f[n] = p;
    n++;
`endif
    for (int i = 0; i < sb; i++) begin
      f[n] = 1'b1;
      n++;
    end
  endfunction

  task automatic start(input int sel, input logic [8:0] d);
    @(negedge clk);
    drv(sel, 1'b1, d);
  endtask

  // mode: 0 quiet, 1 random strt, 2 strt held, 3 pulse at clock 40
  task automatic body(input int sel, input logic [15:0] f,
                      input int n, input int mode,
                      input bit chain, input logic [8:0] nd);
    int cyc;
    logic s;
    cyc = n * B;
    @(posedge clk);
    for (int k = 1; k <= cyc; k++) begin
      @(negedge clk);
      if (k == cyc) s = chain;
      else if (mode == 1) s = 1'($urandom % 2);
      else if (mode == 2) s = 1'b1;
      else if (mode == 3) s = (k == 40);
      else s = 1'b0;
      drv(sel, s, (k == cyc && chain) ? nd : 9'($urandom));
      chk($sformatf("tx[%0d] c%0d", sel, k), 32'(otx(sel)),
          32'(f[(k-1)/B]));
      chk($sformatf("busy[%0d] c%0d", sel, k),
          32'(obusy(sel)), 32'd1);
      chk($sformatf("done[%0d] c%0d", sel, k),
          32'(odone(sel)), 32'(k == cyc));
    end
    if (!chain) begin
      @(negedge clk);
      drv(sel, 1'b0, 9'($urandom));
      chk($sformatf("idle_tx[%0d]", sel), 32'(otx(sel)), 32'd1);
      chk($sformatf("idle_busy[%0d]", sel),
          32'(obusy(sel)), 32'd0);
      chk($sformatf("idle_done[%0d]", sel),
          32'(odone(sel)), 32'd0);
    end
  endtask

  typedef struct {
    int         sel;
    logic [8:0] d;
    logic [15:0] f;
    int         n;
  } vec_t;

  vec_t        tbl[3];
  logic [15:0] f;
  int          n;
  int          sel;
  logic [8:0]  d, nd;
  bit          ch;

  initial begin
`ifdef UART_TX_PARITY_EN
    tbl[0] = '{0, 9'h0A5, 16'h054A, 11};
    tbl[1] = '{1, 9'h007, 16'h018E, 9};
    tbl[2] = '{1, 9'h01F, 16'h01BE, 9};
`else
    tbl[0] = '{0, 9'h0A5, 16'h034A, 10};
    tbl[1] = '{1, 9'h01F, 16'h00FE, 8};
    tbl[2] = '{0, 9'h03C, 16'h0278, 10};
`endif

    repeat (3) @(negedge clk);
    chk("rst_tx_a", 32'(tx_a), 32'd1);
    chk("rst_busy_a", 32'(busy_a), 32'd0);
    chk("rst_done_a", 32'(done_a), 32'd0);
    chk("rst_tx_b", 32'(tx_b), 32'd1);
    chk("rst_busy_b", 32'(busy_b), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_tx_a", 32'(tx_a), 32'd1);

    for (int i = 0; i < 3; i++) begin
      start(tbl[i].sel, tbl[i].d);
      body(tbl[i].sel, tbl[i].f, tbl[i].n, 0, 1'b0, 9'd0);
    end

    // strt held high across two frames
    start(0, 9'h03C);
    model(0, 9'h03C, f, n);
    body(0, f, n, 2, 1'b1, 9'h0C3);
    model(0, 9'h0C3, f, n);
    body(0, f, n, 2, 1'b0, 9'd0);

    // stray request mid-frame
    start(0, 9'h0A5);
    model(0, 9'h0A5, f, n);
    body(0, f, n, 3, 1'b0, 9'd0);

    // reset at clock 70, then restart with strt already high
    start(0, 9'h096);
    @(posedge clk);
    repeat (70) @(negedge clk);
    drv(0, 1'b0, 9'h096);
    rst = 1'b1;
    #1;
    chk("arst_tx", 32'(tx_a), 32'd1);
    chk("arst_busy", 32'(busy_a), 32'd0);
    chk("arst_done", 32'(done_a), 32'd0);
    @(negedge clk);
    chk("arst_hold_tx", 32'(tx_a), 32'd1);
    drv(0, 1'b1, 9'h055);
    rst = 1'b0;
    model(0, 9'h055, f, n);
    body(0, f, n, 0, 1'b0, 9'd0);

    ch = 1'b0;
    sel = 0;
    d = '0;
    for (int i = 0; i < 16; i++) begin
      if (!ch) begin
        sel = int'($urandom % 2);
        d = 9'($urandom);
        start(sel, d);
      end
      ch = (i < 15) && ($urandom % 3 == 0);
      nd = 9'($urandom);
      model(sel, d, f, n);
      body(sel, f, n, int'($urandom % 2), ch, nd);
      d = nd;
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vecs, miss);
    $finish;
  end

endmodule
